// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: owns the PC and runs a handshaked FETCH/EXEC/UPDATE loop.
// Optional stall-cycle counter is built when STALL_CNT_EN is defined.
module pc_fetch_sequencer #(
    parameter int PC_W    = 6,
    parameter int PC_LAST = 41,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               halt_req,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic               exec_start,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    pc_out,
    output logic               busy,
    output logic               fault
`ifdef STALL_CNT_EN
    ,
    output logic [15:0]        stall_cycles
`endif
);

    localparam logic [PC_W-1:0] LAST = PC_W'(PC_LAST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_UPDATE,
        S_FAULT
    } state_t;

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_imem_req;
    logic                 r_instr_valid;
    logic                 r_exec_start;
    logic                 r_busy;
    logic                 r_fault;
    logic                 r_halt;
    logic                 r_br_taken;
    logic [PC_W-1:0]      r_br_target;

    logic                 w_halt;
    logic                 w_bad_target;
    logic [PC_W-1:0]      w_pc_seq;

    // A halt raised in the UPDATE cycle itself is honoured right away.
    assign w_halt       = r_halt | halt_req;
    assign w_bad_target = r_br_target > LAST;
    assign w_pc_seq     = (r_pc == LAST) ? '0 : r_pc + 1'b1;

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign instr_out   = r_instr;
    assign instr_valid = r_instr_valid;
    assign exec_start  = r_exec_start;
    assign pc_out      = r_pc;
    assign busy        = r_busy;
    assign fault       = r_fault;

    // Sequencer FSM; every output is a register updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_instr       <= '0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
            r_exec_start  <= 1'b0;
            r_busy        <= 1'b0;
            r_fault       <= 1'b0;
            r_halt        <= 1'b0;
            r_br_taken    <= 1'b0;
            r_br_target   <= '0;
        end else begin
            if (r_busy && halt_req)
                r_halt <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_imem_req <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_instr       <= imem_data;
                        r_imem_req    <= 1'b0;
                        r_instr_valid <= 1'b1;
                        r_exec_start  <= 1'b1;
                        r_state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_exec_start <= 1'b0;
                    if (!r_exec_start && exec_done) begin
                        r_br_taken    <= branch_taken;
                        r_br_target   <= branch_target;
                        r_instr_valid <= 1'b0;
                        r_state       <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (r_br_taken && w_bad_target) begin
                        r_fault <= 1'b1;
                        r_busy  <= 1'b0;
                        r_halt  <= 1'b0;
                        r_state <= S_FAULT;
                    end else begin
                        r_pc <= r_br_taken ? r_br_target : w_pc_seq;
                        if (w_halt) begin
                            r_halt  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_imem_req <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef STALL_CNT_EN
    logic [15:0] r_stall;
    logic        w_stall_inc;

    assign w_stall_inc =
        ((r_state == S_FETCH) && !imem_ack) ||
        ((r_state == S_EXEC) && !r_exec_start && !exec_done);
    assign stall_cycles = r_stall;

    // Saturating stall counter, restarted whenever a run begins from IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall <= '0;
        else if (r_state == S_IDLE && start)
            r_stall <= '0;
        else if (w_stall_inc && r_stall != 16'hFFFF)
            r_stall <= r_stall + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: randomized memory/execute responder with a
// transaction-level PC model.
module tb_pc_fetch_sequencer;

    localparam int PC_LAST = 41;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = '0;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [5:0]  branch_target = '0;

    logic        imem_req;
    logic [5:0]  imem_addr;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        exec_start;
    logic [5:0]  pc_out;
    logic        busy;
    logic        fault;
`ifdef STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    pc_fetch_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .halt_req      (halt_req),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_data     (imem_data),
        .instr_out     (instr_out),
        .instr_valid   (instr_valid),
        .exec_start    (exec_start),
        .exec_done     (exec_done),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_out        (pc_out),
        .busy          (busy),
        .fault         (fault)
`ifdef STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [0:PC_LAST];
    int          m_pc;

    logic [5:0]  o_addr;
    logic [15:0] o_ins1;
    logic [15:0] o_ins_upd;
    logic        o_vld1, o_vldL, o_vldU, o_stable;
    int          o_starts, o_t0;
    bit          o_to;
    logic [5:0]  o_pc;
    logic        o_busy, o_fault, o_req;

    function automatic int ref_next(int pc, bit tk, int tg);
        if (tk)
            return (tg <= PC_LAST) ? tg : pc;
        return (pc + 1) % (PC_LAST + 1);
    endfunction

    // Plays memory and execute stage for one instruction, recording observations.
    task automatic do_instr(input int ad, input int dd, input bit tk,
                            input logic [5:0] tg, input bit hlt);
        int n;
        o_to = 0; o_stable = 1; o_starts = 0; n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk); n++;
        end
        if (imem_req !== 1'b1) begin
            o_to = 1;
            return;
        end
        o_t0 = cyc;
        o_addr = imem_addr;
        for (int k = 0; k < ad; k++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== o_addr) o_stable = 0;
        end
        imem_ack = 1'b1;
        imem_data = (o_addr <= PC_LAST) ? mem[o_addr] : 16'h0;
        @(negedge clk);
        imem_ack = 1'b0;
        imem_data = 16'($urandom);
        o_ins1 = instr_out; o_vld1 = instr_valid; o_starts += int'(exec_start);
        exec_done = 1'b1; branch_taken = 1'b1; branch_target = 6'h3F;
        halt_req = hlt;
        @(negedge clk);
        o_starts += int'(exec_start);
        halt_req = 1'b0;
        exec_done = 1'b0;
        branch_taken = 1'($urandom); branch_target = 6'($urandom);
        imem_ack = 1'b1;
        for (int k = 0; k < dd; k++) begin
            @(negedge clk);
            o_starts += int'(exec_start);
        end
        o_vldL = instr_valid;
        imem_ack = 1'b0;
        exec_done = 1'b1; branch_taken = tk; branch_target = tg;
        @(negedge clk);
        o_starts += int'(exec_start);
        exec_done = 1'b0; branch_taken = 1'b0;
        o_ins_upd = instr_out; o_vldU = instr_valid;
        @(negedge clk);
        o_pc = pc_out; o_busy = busy; o_fault = fault; o_req = imem_req;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1;
        #3;
        checks++;
        if ({imem_req, instr_valid, exec_start, busy, fault} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 00000",
                     {imem_req, instr_valid, exec_start, busy, fault});
        end
        checks++;
        if (pc_out !== 6'd0 || instr_out !== 16'd0) begin
            errors++;
            $display("FAIL reset_regs got pc=%0d ins=%h exp 0/0", pc_out, instr_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0;
    endtask

    task automatic test_sequential();
        int t_prev = 0;
        int nxt;
        for (int i = 0; i < 8; i++) begin
            do_instr(0, 0, 1'b0, 6'd0, 1'b0);
            nxt = ref_next(m_pc, 1'b0, 0);
            checks++;
            if (o_to || o_addr !== 6'(m_pc)) begin
                errors++;
                $display("FAIL seq_addr got %0d to=%0d exp %0d", o_addr, o_to, m_pc);
            end
            checks++;
            if (o_ins1 !== mem[m_pc] || o_vld1 !== 1'b1 || o_starts != 1) begin
                errors++;
                $display("FAIL seq_exec got ins=%h v=%b st=%0d exp ins=%h v=1 st=1",
                         o_ins1, o_vld1, o_starts, mem[m_pc]);
            end
            checks++;
            if (o_pc !== 6'(nxt) || o_req !== 1'b1) begin
                errors++;
                $display("FAIL seq_pc got %0d req=%b exp %0d req=1", o_pc, o_req, nxt);
            end
            if (i > 0) begin
                checks++;
                if (o_t0 - t_prev != 4) begin
                    errors++;
                    $display("FAIL seq_period got %0d exp 4", o_t0 - t_prev);
                end
            end
            t_prev = o_t0;
            m_pc = nxt;
        end
    endtask

    task automatic test_random();
        int ad, dd, tg, nxt;
        bit tk;
        for (int i = 0; i < 30; i++) begin
            ad = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            tk = 1'($urandom_range(0, 1));
            tg = $urandom_range(0, PC_LAST);
            do_instr(ad, dd, tk, 6'(tg), 1'b0);
            nxt = ref_next(m_pc, tk, tg);
            checks++;
            if (o_to || o_addr !== 6'(m_pc) || o_stable !== 1'b1) begin
                errors++;
                $display("FAIL rnd_fetch got %0d st=%b exp %0d st=1", o_addr, o_stable, m_pc);
            end
            checks++;
            if (o_ins1 !== mem[m_pc] || o_ins_upd !== mem[m_pc]) begin
                errors++;
                $display("FAIL rnd_instr got %h/%h exp %h", o_ins1, o_ins_upd, mem[m_pc]);
            end
            checks++;
            if (o_starts != 1 || o_vldL !== 1'b1 || o_vldU !== 1'b0) begin
                errors++;
                $display("FAIL rnd_exec got st=%0d vL=%b vU=%b exp 1/1/0",
                         o_starts, o_vldL, o_vldU);
            end
            checks++;
            if (o_pc !== 6'(nxt) || o_req !== 1'b1 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL rnd_pc got %0d req=%b exp %0d req=1", o_pc, o_req, nxt);
            end
            m_pc = nxt;
        end
    endtask

    task automatic test_wrap();
        do_instr(0, 0, 1'b1, 6'd39, 1'b0);
        m_pc = 39;
        for (int i = 0; i < 3; i++) begin
            do_instr(0, 0, 1'b0, 6'd0, 1'b0);
            m_pc = ref_next(m_pc, 1'b0, 0);
            checks++;
            if (o_pc !== 6'(m_pc)) begin
                errors++;
                $display("FAIL wrap_pc got %0d exp %0d", o_pc, m_pc);
            end
        end
        do_instr(0, 0, 1'b0, 6'd0, 1'b0);
        checks++;
        if (o_to || o_addr !== 6'd0) begin
            errors++;
            $display("FAIL wrap_addr got %0d exp 0", o_addr);
        end
        m_pc = 1;
    endtask

    task automatic test_branch();
        do_instr(1, 0, 1'b1, 6'd5, 1'b0);
        do_instr(0, 1, 1'b1, 6'd10, 1'b0);
        checks++;
        if (o_addr !== 6'd5 || o_pc !== 6'd10) begin
            errors++;
            $display("FAIL br_pc got addr=%0d pc=%0d exp 5/10", o_addr, o_pc);
        end
        do_instr(0, 0, 1'b0, 6'd0, 1'b0);
        checks++;
        if (o_addr !== 6'd10) begin
            errors++;
            $display("FAIL br_addr got %0d exp 10", o_addr);
        end
        m_pc = 11;
    endtask

    task automatic test_halt();
        do_instr(0, 0, 1'b1, 6'd3, 1'b0);
        start = 1'b0;
        do_instr(1, 1, 1'b0, 6'd0, 1'b1);
        checks++;
        if (o_addr !== 6'd3 || o_pc !== 6'd4 || o_busy !== 1'b0 || o_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_stop got addr=%0d pc=%0d busy=%b req=%b exp 3/4/0/0",
                     o_addr, o_pc, o_busy, o_req);
        end
        halt_req = 1'b1;
        repeat (3) @(negedge clk);
        halt_req = 1'b0;
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || pc_out !== 6'd4) begin
            errors++;
            $display("FAIL halt_idle got req=%b busy=%b pc=%0d exp 0/0/4",
                     imem_req, busy, pc_out);
        end
        start = 1'b1;
        do_instr(0, 0, 1'b0, 6'd0, 1'b0);
        checks++;
        if (o_to || o_addr !== 6'd4 || o_req !== 1'b1) begin
            errors++;
            $display("FAIL halt_resume got addr=%0d req=%b exp 4/1", o_addr, o_req);
        end
        m_pc = 5;
    endtask

    task automatic test_fault();
        int tg;
        tg = $urandom_range(PC_LAST + 1, 63);
        do_instr(0, 0, 1'b1, 6'(tg), 1'b0);
        checks++;
        if (o_fault !== 1'b1 || o_busy !== 1'b0 || o_pc !== 6'(m_pc) || o_req !== 1'b0) begin
            errors++;
            $display("FAIL fault_set got f=%b b=%b pc=%0d exp 1/0/%0d",
                     o_fault, o_busy, o_pc, m_pc);
        end
        start = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b0 || fault !== 1'b1 || pc_out !== 6'(m_pc)) begin
            errors++;
            $display("FAIL fault_hold got req=%b b=%b f=%b pc=%0d exp 0/0/1/%0d",
                     imem_req, busy, fault, pc_out, m_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || pc_out !== 6'd0) begin
            errors++;
            $display("FAIL fault_clear got f=%b pc=%0d exp 0/0", fault, pc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 0;
    endtask

    task automatic test_reset_mid();
        do_instr(0, 0, 1'b0, 6'd0, 1'b0);
        do_instr(2, 0, 1'b0, 6'd0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || pc_out !== 6'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstf got req=%b pc=%0d busy=%b exp 0/0/0", imem_req, pc_out, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b1; imem_data = mem[0];
        @(negedge clk);
        imem_ack = 1'b0;
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL rste_pre got v=%b exp 1", instr_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || exec_start !== 1'b0 || instr_out !== 16'd0) begin
            errors++;
            $display("FAIL rste got v=%b es=%b ins=%h exp 0/0/0",
                     instr_valid, exec_start, instr_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        do_instr(1, 1, 1'b0, 6'd0, 1'b0);
        checks++;
        if (o_to || o_addr !== 6'd0 || o_ins1 !== mem[0] || o_pc !== 6'd1) begin
            errors++;
            $display("FAIL rst_restart got addr=%0d pc=%0d exp 0/1", o_addr, o_pc);
        end
        m_pc = 1;
    endtask

`ifdef STALL_CNT_EN
    task automatic test_stall();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        do_instr(3, 2, 1'b0, 6'd0, 1'b0);
        checks++;
        if (stall_cycles !== 16'd5) begin
            errors++;
            $display("FAIL stall_cnt got %0d exp 5", stall_cycles);
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (stall_cycles !== 16'd0 || imem_req !== 1'b0 || pc_out !== 6'd0) begin
            errors++;
            $display("FAIL stall_rst got cnt=%0d req=%b pc=%0d exp 0/0/0",
                     stall_cycles, imem_req, pc_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i <= PC_LAST; i++)
            mem[i] = 16'($urandom);
        test_reset();
        test_sequential();
        test_random();
        test_wrap();
        test_branch();
        test_halt();
        test_fault();
        test_reset_mid();
`ifdef STALL_CNT_EN
        test_stall();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
